// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared constants and packet-split decode for the fetch buffer
package fetch_buffer_pkg;

   localparam int          EXC_WIDTH     = 7;
   localparam logic [31:0] INST_NOP_ZERO = 32'h0;

   // How an accepted fetch packet is broken into queue entries
   typedef enum logic [1:0] {
      SPLIT_NONE   = 2'd0,  // nothing pushed this cycle
      SPLIT_EXC    = 2'd1,  // one zero-instruction entry carrying the exception
      SPLIT_ONE_HI = 2'd2,  // fetch started at PC[2]=1, only the upper word is wanted
      SPLIT_TWO    = 2'd3   // both words of the aligned block
   } split_e;

   function automatic split_e split_kind(input logic                 accept,
                                         input logic [EXC_WIDTH-1:0] exc,
                                         input logic                 pc_bit2);
      split_e kind;
      if (!accept)
         kind = SPLIT_NONE;
      else if (exc != '0)
         kind = SPLIT_EXC;
      else if (pc_bit2)
         kind = SPLIT_ONE_HI;
      else
         kind = SPLIT_TWO;
      return kind;
   endfunction

   function automatic logic [1:0] split_entries(input split_e kind);
      logic [1:0] n;
      case (kind)
         SPLIT_NONE: n = 2'd0;
         SPLIT_TWO:  n = 2'd2;
         default:    n = 2'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// rtl/fetch_buffer_ram.sv - DEPTH-entry register array, two write ports and two read ports
module fetch_buffer_ram
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int COOKIE_WIDTH = 32,
   parameter int AW           = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    we0,
   input  logic                    we1,
   input  logic [AW-1:0]           waddr,
   input  logic [31:0]             w_inst0,
   input  logic [31:0]             w_pc0,
   input  logic [COOKIE_WIDTH-1:0] w_cookie0,
   input  logic [EXC_WIDTH-1:0]    w_exc0,
   input  logic [31:0]             w_inst1,
   input  logic [31:0]             w_pc1,
   input  logic [COOKIE_WIDTH-1:0] w_cookie1,
   input  logic [EXC_WIDTH-1:0]    w_exc1,
   input  logic [AW-1:0]           raddr,
   output logic [31:0]             r_inst0,
   output logic [31:0]             r_pc0,
   output logic [COOKIE_WIDTH-1:0] r_cookie0,
   output logic [EXC_WIDTH-1:0]    r_exc0,
   output logic [31:0]             r_inst1,
   output logic [31:0]             r_pc1,
   output logic [COOKIE_WIDTH-1:0] r_cookie1,
   output logic [EXC_WIDTH-1:0]    r_exc1
);

   logic [31:0]             inst_mem   [DEPTH];
   logic [31:0]             pc_mem     [DEPTH];
   logic [COOKIE_WIDTH-1:0] cookie_mem [DEPTH];
   logic [EXC_WIDTH-1:0]    exc_mem    [DEPTH];

   logic [AW-1:0]    waddr1;
   logic [AW-1:0]    raddr1;
   logic [DEPTH-1:0] sel0;
   logic [DEPTH-1:0] sel1;

   // Second port always targets the slot after the first, wrapping naturally
   assign waddr1 = waddr + AW'(1);
   assign raddr1 = raddr + AW'(1);

   // Decode the two write addresses into per-entry write enables
   always_comb begin
      sel0        = '0;
      sel1        = '0;
      sel0[waddr]  = we0;
      sel1[waddr1] = we1;
   end

   // Entry storage; contents survive flush and reset, only pointers qualify them
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (sel0[i]) begin
            inst_mem[i]   <= w_inst0;
            pc_mem[i]     <= w_pc0;
            cookie_mem[i] <= w_cookie0;
            exc_mem[i]    <= w_exc0;
         end else if (sel1[i]) begin
            inst_mem[i]   <= w_inst1;
            pc_mem[i]     <= w_pc1;
            cookie_mem[i] <= w_cookie1;
            exc_mem[i]    <= w_exc1;
         end
      end
   end

   assign r_inst0   = inst_mem[raddr];
   assign r_pc0     = pc_mem[raddr];
   assign r_cookie0 = cookie_mem[raddr];
   assign r_exc0    = exc_mem[raddr];
   assign r_inst1   = inst_mem[raddr1];
   assign r_pc1     = pc_mem[raddr1];
   assign r_cookie1 = cookie_mem[raddr1];
   assign r_exc1    = exc_mem[raddr1];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction queue between icache and decode, two-wide dequeue
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int COOKIE_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [63:0]             in_data,
   input  logic [31:0]             in_pc,
   input  logic [COOKIE_WIDTH-1:0] in_cookie,
   input  logic [EXC_WIDTH-1:0]    in_exception,
   output logic                    in_ready,
   output logic [1:0]              out_valid,
   output logic [31:0]             out_inst0,
   output logic [31:0]             out_inst1,
   output logic [31:0]             out_pc0,
   output logic [31:0]             out_pc1,
   output logic [COOKIE_WIDTH-1:0] out_cookie0,
   output logic [COOKIE_WIDTH-1:0] out_cookie1,
   output logic [EXC_WIDTH-1:0]    out_exc0,
   output logic [EXC_WIDTH-1:0]    out_exc1,
   input  logic [1:0]              pop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;

   logic       push_ok;
   split_e     kind;
   logic [1:0] push_n;
   logic [1:0] pop_req;
   logic [1:0] pop_n;

   logic [31:0]             w_inst0;
   logic [31:0]             r_inst0;
   logic [31:0]             r_inst1;
   logic [31:0]             r_pc0;
   logic [31:0]             r_pc1;
   logic [COOKIE_WIDTH-1:0] r_cookie0;
   logic [COOKIE_WIDTH-1:0] r_cookie1;
   logic [EXC_WIDTH-1:0]    r_exc0;
   logic [EXC_WIDTH-1:0]    r_exc1;

   // Room for a whole two-entry packet, judged only from registered occupancy
   assign in_ready = (count <= CW'(DEPTH - 2));

   // Packets arriving without room are dropped; flush discards them too
   assign push_ok = in_valid && in_ready && !flush;
   assign kind    = split_kind(push_ok, in_exception, in_pc[2]);
   assign push_n  = split_entries(kind);

   // Clamp the decoder's request to 2, then to what is actually queued
   assign pop_req = (pop > 2'd2) ? 2'd2 : pop;
   assign pop_n   = (CW'(pop_req) > count) ? count[1:0] : pop_req;

   // First entry's word depends on why the packet is short
   always_comb begin
      w_inst0 = in_data[31:0];
      if (kind == SPLIT_EXC)
         w_inst0 = INST_NOP_ZERO;
      else if (kind == SPLIT_ONE_HI)
         w_inst0 = in_data[63:32];
   end

   fetch_buffer_ram #(
      .DEPTH        (DEPTH),
      .COOKIE_WIDTH (COOKIE_WIDTH),
      .AW           (AW)
   ) u_ram (
      .clk       (clk),
      .we0       (push_n != 2'd0),
      .we1       (kind == SPLIT_TWO),
      .waddr     (wptr),
      .w_inst0   (w_inst0),
      .w_pc0     (in_pc),
      .w_cookie0 (in_cookie),
      .w_exc0    (in_exception),
      .w_inst1   (in_data[63:32]),
      .w_pc1     (in_pc + 32'd4),
      .w_cookie1 (in_cookie),
      .w_exc1    (in_exception),
      .raddr     (rptr),
      .r_inst0   (r_inst0),
      .r_pc0     (r_pc0),
      .r_cookie0 (r_cookie0),
      .r_exc0    (r_exc0),
      .r_inst1   (r_inst1),
      .r_pc1     (r_pc1),
      .r_cookie1 (r_cookie1),
      .r_exc1    (r_exc1)
   );

   // Pointer and occupancy update: reset beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + AW'(push_n);
         rptr  <= rptr + AW'(pop_n);
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   assign out_valid[0] = (count != '0);
   assign out_valid[1] = (count >= CW'(2));

   // Stale slots are masked so decode never sees leftover contents
   assign out_inst0   = out_valid[0] ? r_inst0   : '0;
   assign out_pc0     = out_valid[0] ? r_pc0     : '0;
   assign out_cookie0 = out_valid[0] ? r_cookie0 : '0;
   assign out_exc0    = out_valid[0] ? r_exc0    : '0;
   assign out_inst1   = out_valid[1] ? r_inst1   : '0;
   assign out_pc1     = out_valid[1] ? r_pc1     : '0;
   assign out_cookie1 = out_valid[1] ? r_cookie1 : '0;
   assign out_exc1    = out_valid[1] ? r_exc1    : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed and model-checked bench for fetch_buffer
module tb_fetch_buffer;

   localparam int DEPTH = 8;
   localparam int CW    = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          in_valid;
   logic [63:0]   in_data;
   logic [31:0]   in_pc;
   logic [CW-1:0] in_cookie;
   logic [6:0]    in_exception;
   logic          in_ready;
   logic [1:0]    out_valid;
   logic [31:0]   out_inst0, out_inst1, out_pc0, out_pc1;
   logic [CW-1:0] out_cookie0, out_cookie1;
   logic [6:0]    out_exc0, out_exc1;
   logic [1:0]    pop;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] cookie;
      logic [6:0]  exc;
   } ent_t;

   ent_t q[$];

   always #5 clk = ~clk;

   fetch_buffer #(.DEPTH(DEPTH), .COOKIE_WIDTH(CW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_pc        (in_pc),
      .in_cookie    (in_cookie),
      .in_exception (in_exception),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_inst0    (out_inst0),
      .out_inst1    (out_inst1),
      .out_pc0      (out_pc0),
      .out_pc1      (out_pc1),
      .out_cookie0  (out_cookie0),
      .out_cookie1  (out_cookie1),
      .out_exc0     (out_exc0),
      .out_exc1     (out_exc1),
      .pop          (pop)
   );

   // Fetch must never present a packet while the buffer reports no room
   always @(posedge clk) begin
      if (rstn === 1'b1)
         assert (!(in_valid && !in_ready)) else $error("in_ready protocol violation");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pkt(input logic [31:0] pc, input logic [63:0] data,
                           input logic [31:0] cookie, input logic [6:0] exc);
      in_valid = 1'b1; in_pc = pc; in_data = data; in_cookie = cookie; in_exception = exc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_pop(input logic [1:0] n);
      pop = n;
      tick();
      pop = 2'd0;
   endtask

   function automatic logic [63:0] pair(input logic [31:0] pc);
      return {32'hA500_0000 | (pc + 32'd4), 32'hA500_0000 | pc};
   endfunction

   // Reference queue step, using the inputs presented during the cycle that just ended
   task automatic model_step(input logic ready_before);
      int   n;
      ent_t e;
      if (flush) begin
         q.delete();
         return;
      end
      n = (pop > 2) ? 2 : int'(pop);
      for (int i = 0; i < n && q.size() > 0; i++) void'(q.pop_front());
      if (in_valid && ready_before) begin
         e.cookie = in_cookie;
         e.exc    = in_exception;
         e.pc     = in_pc;
         if (in_exception != 0) begin
            e.inst = 32'h0;
            q.push_back(e);
         end else if (in_pc[2]) begin
            e.inst = in_data[63:32];
            q.push_back(e);
         end else begin
            e.inst = in_data[31:0];
            q.push_back(e);
            e.inst = in_data[63:32];
            e.pc   = in_pc + 32'd4;
            q.push_back(e);
         end
      end
   endtask

   task automatic model_compare();
      logic [1:0] ev;
      ev = {q.size() >= 2, q.size() >= 1};
      check("rnd_valid", {62'd0, out_valid}, {62'd0, ev});
      check("rnd_ready", {63'd0, in_ready}, {63'd0, q.size() <= DEPTH - 2});
      if (ev[0]) begin
         check("rnd_slot0", {out_inst0, out_pc0}, {q[0].inst, q[0].pc});
         check("rnd_meta0", {25'd0, out_exc0, out_cookie0}, {25'd0, q[0].exc, q[0].cookie});
      end
      if (ev[1]) begin
         check("rnd_slot1", {out_inst1, out_pc1}, {q[1].inst, q[1].pc});
         check("rnd_meta1", {25'd0, out_exc1, out_cookie1}, {25'd0, q[1].exc, q[1].cookie});
      end
   endtask

   initial begin
      logic ready_now;
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0;
      in_cookie = '0; in_exception = '0; pop = 2'd0;
      tick();
      tick();
      rstn = 1'b1;
      check("rst_valid", {62'd0, out_valid}, 64'd0);
      check("rst_ready", {63'd0, in_ready}, 64'd1);
      check("rst_data0", {out_inst0, out_pc0}, 64'd0);

      // Aligned two-instruction packet
      push_pkt(32'h1c00_0000, 64'h0280_0421_0280_0400, 32'hC0C0_0001, 7'd0);
      check("two_valid", {62'd0, out_valid}, 64'd3);
      check("two_pc", {out_pc1, out_pc0}, 64'h1c00_0004_1c00_0000);
      check("two_inst", {out_inst1, out_inst0}, 64'h0280_0421_0280_0400);
      check("two_cookie1", {32'd0, out_cookie1}, 64'hC0C0_0001);
      do_pop(2'd2);
      check("drain_valid", {62'd0, out_valid}, 64'd0);
      check("drain_gate", {out_inst0, out_pc0}, 64'd0);

      // Odd-word start pushes only the upper word
      push_pkt(32'h1c00_0004, 64'hAAAA_0001_BBBB_0002, 32'h5, 7'd0);
      check("hi_valid", {62'd0, out_valid}, 64'd1);
      check("hi_slot0", {out_inst0, out_pc0}, 64'hAAAA_0001_1c00_0004);
      do_pop(2'd1);

      // Exception packet becomes a single zero instruction
      push_pkt(32'h1c00_0010, 64'hDEAD_BEEF_CAFE_F00D, 32'h6, 7'h08);
      check("exc_valid", {62'd0, out_valid}, 64'd1);
      check("exc_slot0", {out_inst0, out_pc0}, 64'h0000_0000_1c00_0010);
      check("exc_code", {57'd0, out_exc0}, 64'h08);
      do_pop(2'd1);

      // Fill from wptr=4 so the writes wrap through slot 0
      for (int k = 0; k < 4; k++) begin
         push_pkt(32'h100 + 32'(8 * k), pair(32'h100 + 32'(8 * k)), 32'h7, 7'd0);
         if (k == 2) check("fill6_ready", {63'd0, in_ready}, 64'd1);
      end
      check("full_ready", {63'd0, in_ready}, 64'd0);
      check("full_head", {out_pc1, out_pc0}, 64'h0000_0104_0000_0100);
      do_pop(2'd2);
      check("unfull_ready", {63'd0, in_ready}, 64'd1);
      check("order_a", {out_inst1, out_pc0}, {32'hA500_010C, 32'h108});
      do_pop(2'd2);
      check("order_b", {out_pc1, out_pc0}, 64'h0000_0114_0000_0110);
      do_pop(2'd2);
      do_pop(2'd1);
      check("one_left", {out_pc0, 30'd0, out_valid}, {32'h11C, 32'd1});

      // Over-pop must stop at empty
      do_pop(2'd2);
      check("underflow_valid", {62'd0, out_valid}, 64'd0);
      do_pop(2'd2);
      check("empty_ready", {63'd0, in_ready}, 64'd1);

      // Flush beats a same-cycle push
      flush = 1'b1;
      push_pkt(32'h200, pair(32'h200), 32'h8, 7'd0);
      flush = 1'b0;
      check("flush_push_valid", {62'd0, out_valid}, 64'd0);
      check("flush_push_ready", {63'd0, in_ready}, 64'd1);

      // Rebuild from pointer 0 so a two-entry pop starts at slot DEPTH-1
      for (int k = 0; k < 3; k++) push_pkt(32'h300 + 32'(8 * k), pair(32'h300 + 32'(8 * k)), 32'h9, 7'd0);
      for (int k = 0; k < 3; k++) do_pop(2'd2);
      push_pkt(32'h404, 64'h1111_0404_2222_0000, 32'h9, 7'd0);
      push_pkt(32'h408, pair(32'h408), 32'h9, 7'd0);
      do_pop(2'd1);
      check("wrap_pc", {out_pc1, out_pc0}, 64'h0000_040C_0000_0408);
      check("wrap_inst", {out_inst1, out_inst0}, {32'hA500_040C, 32'hA500_0408});
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid", {62'd0, out_valid}, 64'd0);

      // Randomised traffic against the reference queue
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         ready_now    = (q.size() <= DEPTH - 2);
         in_valid     = ready_now && ($urandom_range(0, 3) != 0);
         in_pc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         in_data      = {$urandom, $urandom};
         in_cookie    = $urandom;
         in_exception = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
         pop          = 2'($urandom_range(0, 2));
         flush        = ($urandom_range(0, 31) == 0);
         model_compare();
         tick();
         model_step(ready_now);
      end
      in_valid = 1'b0; pop = 2'd0; flush = 1'b0;

      // Reset in the middle of traffic behaves like power-up
      push_pkt(32'h500, pair(32'h500), 32'hA, 7'd0);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("midrst_valid", {62'd0, out_valid}, 64'd0);
      check("midrst_ready", {63'd0, in_ready}, 64'd1);
      check("midrst_data", {out_inst0, out_pc0}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
